// File: rtl/hall_sensor_emulator.sv
// hall_sensor_emulator: programmable-period Hall rotor with shoot-through latch.
// Define HALL_EMU_COMM_CHECK_EN to count commutation patterns that disagree with the Hall step.
module hall_sensor_emulator #(
    parameter int PERIOD_W   = 16,
    parameter int ERR_W      = 8,
    parameter int START_STEP = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_dir,
    input  logic                i_a,
    input  logic                i_b,
    input  logic                i_c,
    input  logic                i_aa,
    input  logic                i_bb,
    input  logic                i_cc,
    output logic                o_h1,
    output logic                o_h2,
    output logic                o_h3,
    output logic [2:0]          o_step,
    output logic                o_step_stb,
    output logic                o_fault,
    output logic [ERR_W-1:0]    o_err_cnt
);
    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;
    localparam logic [2:0] START    = 3'(START_STEP);

    function automatic logic [2:0] hall_of(input logic [2:0] s);
        return s == 3'd0 ? 3'b001 :
               s == 3'd1 ? 3'b101 :
               s == 3'd2 ? 3'b100 :
               s == 3'd3 ? 3'b110 :
               s == 3'd4 ? 3'b010 : 3'b011;
    endfunction

    logic [1:0]          r_state;
    logic [2:0]          r_step;
    logic [2:0]          r_hall;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_per;
    logic                r_stb;
    logic                w_shoot;
    logic                w_bound;
    logic [2:0]          w_next;

    always_comb begin
        w_shoot = (i_a & i_aa) | (i_b & i_bb) | (i_c & i_cc);
        w_bound = (r_state == ST_RUN) && (r_cnt == r_per - PERIOD_W'(1));
        w_next  = i_dir ? (r_step == 3'd0 ? 3'd5 : r_step - 3'd1)
                        : (r_step == 3'd5 ? 3'd0 : r_step + 3'd1);
    end

    // A fault takes priority over any step boundary on the same edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_STOP;
            r_step  <= START;
            r_hall  <= hall_of(START);
            r_cnt   <= '0;
            r_per   <= '0;
            r_stb   <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            if (w_shoot || r_state == ST_FAULT) begin
                r_state <= ST_FAULT;
            end else if (r_state == ST_STOP) begin
                if (i_period != '0) begin
                    r_per   <= i_period;
                    r_cnt   <= '0;
                    r_state <= ST_RUN;
                end
            end else if (w_bound) begin
                r_step  <= w_next;
                r_hall  <= hall_of(w_next);
                r_stb   <= 1'b1;
                r_cnt   <= '0;
                r_per   <= i_period;
                r_state <= (i_period == '0) ? ST_STOP : ST_RUN;
            end else begin
                r_cnt <= r_cnt + PERIOD_W'(1);
            end
        end
    end

    assign {o_h3, o_h2, o_h1} = r_hall;
    assign o_step             = r_step;
    assign o_step_stb         = r_stb;
    assign o_fault            = (r_state == ST_FAULT);

`ifdef HALL_EMU_COMM_CHECK_EN
    logic [5:0]       w_gates;
    logic [5:0]       w_exp;
    logic             w_bad;
    logic [ERR_W-1:0] r_err;

    // Gate vector order {A,AA,B,BB,C,CC}; all-off means coasting and is accepted
    always_comb begin
        w_gates = {i_a, i_aa, i_b, i_bb, i_c, i_cc};
        w_exp   = r_step == 3'd0 ? 6'b100100 :
                  r_step == 3'd1 ? 6'b100001 :
                  r_step == 3'd2 ? 6'b001001 :
                  r_step == 3'd3 ? 6'b011000 :
                  r_step == 3'd4 ? 6'b010010 : 6'b000110;
        w_bad   = w_bound && !w_shoot && (w_gates != w_exp) && (w_gates != '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_err <= '0;
        else if (w_bad && r_err != '1)
            r_err <= r_err + ERR_W'(1);
    end

    assign o_err_cnt = r_err;
`else
    assign o_err_cnt = '0;
`endif
endmodule

// File: tb/tb_hall_sensor_emulator.sv
// tb_hall_sensor_emulator: directed scenarios for the Hall emulator with hand-computed expectations.
module tb_hall_sensor_emulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] period = 16'd0;
    logic        dir = 1'b0;
    logic        a = 1'b0, b = 1'b0, c = 1'b0, aa = 1'b0, bb = 1'b0, cc = 1'b0;
    logic        h1, h2, h3, stb, fault;
    logic [2:0]  step;
    logic [7:0]  err;
    int          total = 0;
    int          bad = 0;
    logic [2:0]  hall_tbl [6] = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};

    hall_sensor_emulator #(.PERIOD_W(16), .ERR_W(8), .START_STEP(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_period(period), .i_dir(dir),
        .i_a(a), .i_b(b), .i_c(c), .i_aa(aa), .i_bb(bb), .i_cc(cc),
        .o_h1(h1), .o_h2(h2), .o_h3(h3), .o_step(step), .o_step_stb(stb),
        .o_fault(fault), .o_err_cnt(err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts cycles until the step changes (bounded), plus STB samples seen on the way
    task automatic measure(input int max, output int n, output int pulses);
        logic [2:0] s0;
        s0 = step;
        n = 0;
        pulses = 0;
        do begin
            tick(1);
            n++;
            if (stb) pulses++;
        end while (step === s0 && n < max);
    endtask

    task automatic test_reset();
        rst = 1'b1; period = 16'd50; dir = 1'b0;
        tick(1);
        total++; if (step !== 3'd0) begin bad++; $display("FAIL reset_step got=%0d want=0", step); end
        total++; if ({h3, h2, h1} !== 3'b001) begin bad++; $display("FAIL reset_hall got=%b want=001", {h3, h2, h1}); end
        total++; if (stb !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL reset_flags got stb=%b fault=%b want 0 0", stb, fault); end
        total++; if (err !== 8'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", err); end
    endtask

    task automatic test_forward();
        int n, p, sum;
        rst = 1'b0;
        tick(1);
        total++; if (stb !== 1'b0 || step !== 3'd0) begin bad++; $display("FAIL load_edge got step=%0d stb=%b want 0 0", step, stb); end
        sum = 0;
        for (int k = 1; k <= 6; k++) begin
            measure(100, n, p);
            sum += p;
            total++; if (n != 50) begin bad++; $display("FAIL fwd_len k=%0d got=%0d want=50", k, n); end
            total++; if (step !== 3'(k % 6) || {h3, h2, h1} !== hall_tbl[k % 6]) begin bad++; $display("FAIL fwd_state k=%0d got step=%0d hall=%b want step=%0d hall=%b", k, step, {h3, h2, h1}, k % 6, hall_tbl[k % 6]); end
            total++; if (stb !== 1'b1) begin bad++; $display("FAIL fwd_stb k=%0d got=%b want=1", k, stb); end
        end
        total++; if (sum != 6) begin bad++; $display("FAIL fwd_stb_count got=%0d want=6", sum); end
    endtask

    task automatic test_reverse();
        int n, p;
        measure(100, n, p);
        measure(100, n, p);
        total++; if (step !== 3'd2) begin bad++; $display("FAIL rev_setup got=%0d want=2", step); end
        tick(20);
        dir = 1'b1;
        measure(100, n, p);
        total++; if (n != 30 || step !== 3'd1 || {h3, h2, h1} !== 3'b101) begin bad++; $display("FAIL rev_first got n=%0d step=%0d hall=%b want 30 1 101", n, step, {h3, h2, h1}); end
        measure(100, n, p);
        total++; if (n != 50 || step !== 3'd0 || {h3, h2, h1} !== 3'b001) begin bad++; $display("FAIL rev_second got n=%0d step=%0d hall=%b want 50 0 001", n, step, {h3, h2, h1}); end
    endtask

    task automatic test_period_change();
        int n, p;
        dir = 1'b0;
        tick(10);
        period = 16'd20;
        measure(100, n, p);
        total++; if (n != 40 || step !== 3'd1) begin bad++; $display("FAIL per_old got n=%0d step=%0d want 40 1", n, step); end
        measure(100, n, p);
        total++; if (n != 20 || step !== 3'd2) begin bad++; $display("FAIL per_new got n=%0d step=%0d want 20 2", n, step); end
        measure(100, n, p);
        total++; if (n != 20 || step !== 3'd3) begin bad++; $display("FAIL per_new2 got n=%0d step=%0d want 20 3", n, step); end
    endtask

    task automatic test_stop_start();
        int n, p;
        period = 16'd0;
        measure(100, n, p);
        total++; if (n != 20 || step !== 3'd4) begin bad++; $display("FAIL stop_last got n=%0d step=%0d want 20 4", n, step); end
        measure(30, n, p);
        total++; if (step !== 3'd4 || p != 0 || {h3, h2, h1} !== 3'b010) begin bad++; $display("FAIL stopped_hold got step=%0d pulses=%0d want 4 0", step, p); end
        period = 16'd10;
        tick(1);
        measure(100, n, p);
        total++; if (n != 10 || step !== 3'd5 || {h3, h2, h1} !== 3'b011) begin bad++; $display("FAIL restart got n=%0d step=%0d want 10 5", n, step); end
    endtask

    task automatic test_fault();
        int n, p;
        tick(3);
        a = 1'b1; aa = 1'b1;
        tick(1);
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_set got=%b want=1", fault); end
        a = 1'b0; aa = 1'b0;
        measure(40, n, p);
        total++; if (step !== 3'd5 || p != 0 || fault !== 1'b1) begin bad++; $display("FAIL fault_freeze got step=%0d pulses=%0d fault=%b want 5 0 1", step, p, fault); end
        rst = 1'b1;
        tick(1);
        total++; if (fault !== 1'b0 || step !== 3'd0 || {h3, h2, h1} !== 3'b001) begin bad++; $display("FAIL fault_clear got fault=%b step=%0d want 0 0", fault, step); end
        rst = 1'b0;
    endtask

    task automatic test_fault_on_boundary();
        int n, p;
        rst = 1'b1; period = 16'd5;
        tick(1);
        rst = 1'b0;
        tick(5);
        b = 1'b1; bb = 1'b1;
        tick(1);
        b = 1'b0; bb = 1'b0;
        total++; if (fault !== 1'b1 || step !== 3'd0 || stb !== 1'b0) begin bad++; $display("FAIL fault_wins got fault=%b step=%0d stb=%b want 1 0 0", fault, step, stb); end
    endtask

    task automatic test_period_one();
        rst = 1'b1; period = 16'd1;
        tick(1);
        rst = 1'b0;
        tick(1);
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            total++; if (step !== 3'(i % 6) || stb !== 1'b1) begin bad++; $display("FAIL per1 i=%0d got step=%0d stb=%b want %0d 1", i, step, stb, i % 6); end
        end
    endtask

`ifdef HALL_EMU_COMM_CHECK_EN
    task automatic test_comm_check();
        int n, p;
        rst = 1'b1; period = 16'd10; dir = 1'b0;
        tick(1);
        rst = 1'b0; a = 1'b1; cc = 1'b1;
        tick(1);
        measure(100, n, p);
        total++; if (err !== 8'd1 || step !== 3'd1) begin bad++; $display("FAIL comm_bad got err=%0d step=%0d want 1 1", err, step); end
        rst = 1'b1; a = 1'b0; cc = 1'b0;
        tick(1);
        rst = 1'b0; a = 1'b1; bb = 1'b1;
        tick(1);
        measure(100, n, p);
        total++; if (err !== 8'd0 || step !== 3'd1) begin bad++; $display("FAIL comm_good got err=%0d step=%0d want 0 1", err, step); end
        a = 1'b0; bb = 1'b0;
        measure(100, n, p);
        total++; if (err !== 8'd0 || step !== 3'd2) begin bad++; $display("FAIL comm_coast got err=%0d step=%0d want 0 2", err, step); end
        a = 1'b1; b = 1'b1; period = 16'd1;
        measure(100, n, p);
        total++; if (err !== 8'd1) begin bad++; $display("FAIL comm_one got=%0d want=1", err); end
        tick(300);
        total++; if (err !== 8'd255 || fault !== 1'b0) begin bad++; $display("FAIL comm_sat got err=%0d fault=%b want 255 0", err, fault); end
        a = 1'b0; b = 1'b0;
    endtask
`else
    task automatic test_comm_check();
        int n, p;
        rst = 1'b1; period = 16'd10; dir = 1'b0;
        tick(1);
        rst = 1'b0; a = 1'b1; cc = 1'b1;
        tick(1);
        measure(100, n, p);
        total++; if (err !== 8'd0 || step !== 3'd1) begin bad++; $display("FAIL comm_off got err=%0d step=%0d want 0 1", err, step); end
        a = 1'b0; cc = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_period_change();
        test_stop_start();
        test_fault();
        test_fault_on_boundary();
        test_period_one();
        test_comm_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
